// File: rtl/cart_image_loader.sv
// cart_image_loader: SPI flash (mode 0, clock/2) reader that streams one
// cartridge image from a flash slot into a 32-bit word memory, captures the
// trailing mapper-flags word and raises cart_ready after a settle delay.
// Optional feature macro: CART_IMAGE_LOADER_CHECKSUM_EN -- reads one extra
// trailer word and flags a mismatch of (image sum + flags + trailer) != 0.
module cart_image_loader #(
  parameter int          ADDR_W        = 15,
  parameter int          IMAGE_WORDS   = 32768,
  parameter logic [23:0] FLASH_BASE    = 24'h100000,
  parameter int          SLOT_SHIFT    = 18,
  parameter int          INDEX_W       = 4,
  parameter int          SETTLE_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               reload,
  input  logic [INDEX_W-1:0] index,
  output logic               flash_csn,
  output logic               flash_sck,
  output logic               flash_mosi,
  input  logic               flash_miso,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_wren,
  output logic [31:0]        flags_out,
  output logic               loading,
  output logic               cart_ready,
  output logic               checksum_err
);

  typedef enum logic [2:0] {
    S_GAP, S_CMD, S_DATA, S_FLAGS, S_SUM, S_SETTLE, S_DONE
  } state_t;

  // Shared counter for the 2-cycle chip-select gap and the settle delay.
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // Word count carries one extra bit so a full 2**ADDR_W image compares cleanly.
  localparam logic [ADDR_W:0]   WORD_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LAST_WORD   = (ADDR_W + 1)'(IMAGE_WORDS - 1);

  state_t               state_q, state_d;
  logic [5:0]           cyc_q, cyc_d;          // cycle within a 32-bit word, 2 per bit
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          tx_q, tx_d;            // command shifter, MSB on mosi
  logic [30:0]          rx_q, rx_d;            // receive shifter
  logic [ADDR_W:0]      word_q, word_d;
  logic [INDEX_W-1:0]   index_lat_q, index_lat_d;
  logic                 mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [31:0]          flags_q, flags_d;
  logic                 ready_q, ready_d;
  logic                 csn_q, csn_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic                 loading_q, loading_d;
  logic                 active_d;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
  logic [31:0]          sum_q, sum_d;
  logic                 err_q, err_d;
`endif

  logic                 word_done;
  logic [31:0]          rx_word;               // 32 bits as received, first byte in [31:24]
  logic [31:0]          rx_le;                 // little-endian packed word
  logic [23:0]          slot_off;
  logic [23:0]          cmd_addr;

  assign word_done = (cyc_q == 6'd63);
  assign rx_word   = {rx_q, flash_miso};
  assign rx_le     = {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
  // Slot address arithmetic is deliberately 24 bits wide so it truncates.
  assign slot_off  = 24'(index_lat_q) << SLOT_SHIFT;
  assign cmd_addr  = FLASH_BASE + slot_off;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d     = state_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    word_d      = word_q;
    index_lat_d = index_lat_q;
    mem_wren_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    flags_d     = flags_q;
    ready_d     = ready_q;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_CMD;
          cnt_d   = '0;
          cyc_d   = '0;
          tx_d    = {8'h03, cmd_addr};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CMD: begin
        cyc_d = cyc_q + 6'd1;
        if (cyc_q[0]) tx_d = {tx_q[30:0], 1'b0};
        if (word_done) state_d = S_DATA;
      end
      S_DATA: begin
        cyc_d = cyc_q + 6'd1;
        if (cyc_q[0]) rx_d = rx_word[30:0];
        if (word_done) begin
          mem_wren_d  = 1'b1;
          mem_addr_d  = word_q[ADDR_W-1:0];
          mem_wdata_d = rx_le;
          word_d      = word_q + WORD_ONE;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
          sum_d       = sum_q + rx_le;
`endif
          if (word_q == LAST_WORD) state_d = S_FLAGS;
        end
      end
      S_FLAGS: begin
        cyc_d = cyc_q + 6'd1;
        if (cyc_q[0]) rx_d = rx_word[30:0];
        if (word_done) begin
          flags_d = rx_le;
          cnt_d   = '0;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
          state_d = S_SUM;
`else
          state_d = S_SETTLE;
`endif
        end
      end
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
      S_SUM: begin
        cyc_d = cyc_q + 6'd1;
        if (cyc_q[0]) rx_d = rx_word[30:0];
        if (word_done) begin
          err_d   = ((sum_q + flags_q + rx_le) != 32'd0);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
`endif
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_GAP;
    endcase

    // Reload wins over everything: a partially shifted word is simply dropped.
    if (reload) begin
      state_d     = S_GAP;
      cnt_d       = '0;
      cyc_d       = '0;
      word_d      = '0;
      index_lat_d = index;
      mem_wren_d  = 1'b0;
      flags_d     = '0;
      ready_d     = 1'b0;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
      sum_d       = '0;
      err_d       = 1'b0;
`endif
    end

    // Pin values are registered from the next state so sck/csn never glitch.
    active_d  = (state_d == S_CMD) || (state_d == S_DATA) ||
                (state_d == S_FLAGS) || (state_d == S_SUM);
    csn_d     = !active_d;
    sck_d     = active_d && cyc_d[0];
    mosi_d    = (state_d == S_CMD) && tx_d[31];
    loading_d = active_d;
  end

  // State and output registers; loading restarts when reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_GAP;
      cyc_q       <= '0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      word_q      <= '0;
      index_lat_q <= '0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      flags_q     <= '0;
      ready_q     <= 1'b0;
      csn_q       <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      loading_q   <= 1'b0;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      word_q      <= word_d;
      index_lat_q <= index_lat_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      flags_q     <= flags_d;
      ready_q     <= ready_d;
      csn_q       <= csn_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      loading_q   <= loading_d;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign flash_csn  = csn_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = mosi_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wren   = mem_wren_q;
  assign flags_out  = flags_q;
  assign loading    = loading_q;
  assign cart_ready = ready_q;
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
  assign checksum_err = err_q;
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_cart_image_loader.sv
// Bench for cart_image_loader: SPI flash model returning byte A[7:0] at
// address A, 16-word image, 8-cycle settle. A second instance with
// FLASH_BASE=24'hF00000 checks command-address truncation.
module tb_cart_image_loader;

  localparam int ADDR_W      = 4;
  localparam int IMAGE_WORDS = 16;
  localparam int SETTLE      = 8;
  localparam int INDEX_W     = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               reload = 1'b0;
  logic [INDEX_W-1:0] index = '0;
  logic               flash_csn, flash_sck, flash_mosi;
  logic               flash_miso = 1'b0;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_wdata, flags_out;
  logic               mem_wren, loading, cart_ready, checksum_err;

  logic               reload_hi = 1'b0;
  logic [INDEX_W-1:0] index_hi = '0;
  logic               hi_csn, hi_sck, hi_mosi;
  logic               hi_miso = 1'b0;
  logic [ADDR_W-1:0]  hi_addr;
  logic [31:0]        hi_wdata, hi_flags;
  logic               hi_wren, hi_loading, hi_ready, hi_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cart_image_loader #(
    .ADDR_W(ADDR_W), .IMAGE_WORDS(IMAGE_WORDS), .FLASH_BASE(24'h100000),
    .SLOT_SHIFT(18), .INDEX_W(INDEX_W), .SETTLE_CYCLES(SETTLE)
  ) u_dut (
    .clock(clock), .reset(reset), .reload(reload), .index(index),
    .flash_csn(flash_csn), .flash_sck(flash_sck), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .flags_out(flags_out), .loading(loading),
    .cart_ready(cart_ready), .checksum_err(checksum_err)
  );

  cart_image_loader #(
    .ADDR_W(ADDR_W), .IMAGE_WORDS(IMAGE_WORDS), .FLASH_BASE(24'hF00000),
    .SLOT_SHIFT(18), .INDEX_W(INDEX_W), .SETTLE_CYCLES(SETTLE)
  ) u_dut_hi (
    .clock(clock), .reset(reset), .reload(reload_hi), .index(index_hi),
    .flash_csn(hi_csn), .flash_sck(hi_sck), .flash_mosi(hi_mosi),
    .flash_miso(hi_miso), .mem_addr(hi_addr), .mem_wdata(hi_wdata),
    .mem_wren(hi_wren), .flags_out(hi_flags), .loading(hi_loading),
    .cart_ready(hi_ready), .checksum_err(hi_err)
  );

  // ---------------- flash model ----------------
  logic        corrupt = 1'b0;
  logic [31:0] exp_s   = '0;
  int unsigned bitcnt  = 0;
  logic [31:0] cmd_sr  = '0;
  logic [31:0] last_cmd = '0;

  function automatic logic [7:0] flash_byte(input logic [23:0] base, input int unsigned off);
    logic [23:0] a;
    logic [7:0]  v;
    a = base + 24'(off);
    v = a[7:0];
    if (corrupt && off == 5) v = ~v;
    if (off >= 68 && off < 72) v = exp_s[8*(off-68) +: 8];
    return v;
  endfunction

  function automatic logic miso_bit(input logic [23:0] base, input int unsigned k);
    logic [7:0] b;
    b = flash_byte(base, k / 8);
    return b[3'(7 - (k % 8))];
  endfunction

  // Command capture on rising sck; chip select high restarts the transaction.
  always @(posedge flash_sck or posedge flash_csn) begin
    if (flash_csn) begin
      bitcnt <= 0;
    end else begin
      if (bitcnt < 32) begin
        cmd_sr <= {cmd_sr[30:0], flash_mosi};
        if (bitcnt == 31) last_cmd <= {cmd_sr[30:0], flash_mosi};
      end
      bitcnt <= bitcnt + 1;
    end
  end

  // Read data shifted out on falling sck (mode 0).
  always @(negedge flash_sck) begin
    if (bitcnt >= 32) flash_miso <= miso_bit(cmd_sr[23:0], bitcnt - 32);
  end

  // Command capture for the high-base instance.
  int unsigned hi_bitcnt  = 0;
  int unsigned hi_cmd_cnt = 0;
  logic [31:0] hi_sr  = '0;
  logic [31:0] hi_cmd = '0;
  always @(posedge hi_sck or posedge hi_csn) begin
    if (hi_csn) begin
      hi_bitcnt <= 0;
    end else begin
      if (hi_bitcnt < 32) begin
        hi_sr <= {hi_sr[30:0], hi_mosi};
        if (hi_bitcnt == 31) begin
          hi_cmd     <= {hi_sr[30:0], hi_mosi};
          hi_cmd_cnt <= hi_cmd_cnt + 1;
        end
      end
      hi_bitcnt <= hi_bitcnt + 1;
    end
  end

  // ---------------- monitor (samples on falling clock) ----------------
  int                ncyc = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                wr_cyc[$];
  int                wide_cnt = 0;
  int                csn_rise_cyc = 0;
  int                ready_rise_cyc = 0;
  logic              prev_wren = 1'b0, prev_csn = 1'b1, prev_ready = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      ncyc++;
      if (mem_wren === 1'b1) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        wr_cyc.push_back(ncyc);
        if (prev_wren) wide_cnt++;
      end
      if (flash_csn === 1'b1 && !prev_csn) csn_rise_cyc = ncyc;
      if (cart_ready === 1'b1 && !prev_ready) ready_rise_cyc = ncyc;
      prev_wren  = (mem_wren === 1'b1);
      prev_csn   = (flash_csn === 1'b1);
      prev_ready = (cart_ready === 1'b1);
    end
  end

  function automatic logic [31:0] exp_word(input int i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wide_cnt = 0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (cart_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reload(input logic [INDEX_W-1:0] idx);
    @(negedge clock);
    reload = 1'b1;
    index  = idx;
    @(negedge clock);
    reload = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++; if (flash_csn !== 1'b1) begin bad++; $display("FAIL reset_csn: got %b want 1", flash_csn); end
    total++; if ({flash_sck, flash_mosi, mem_wren, loading, cart_ready, checksum_err} !== 6'b0) begin
      bad++; $display("FAIL reset_bits: sck/mosi/wren/loading/ready/err got %b want 000000",
                      {flash_sck, flash_mosi, mem_wren, loading, cart_ready, checksum_err});
    end
    total++; if ({mem_addr, mem_wdata, flags_out} !== '0) begin
      bad++; $display("FAIL reset_buses: addr=%h wdata=%h flags=%h want 0", mem_addr, mem_wdata, flags_out);
    end
  endtask

  task automatic test_full_load();
    bit ok;
    clear_log();
    @(negedge clock);
    reset = 1'b0;
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout: cart_ready got 0 want 1"); end
    total++; if (last_cmd !== 32'h03100000) begin bad++; $display("FAIL full_cmd: got %h want 03100000", last_cmd); end
    total++; if (wr_addr.size() != IMAGE_WORDS) begin bad++; $display("FAIL full_count: got %0d want %0d", wr_addr.size(), IMAGE_WORDS); end
    for (int i = 0; i < wr_addr.size() && i < IMAGE_WORDS; i++) begin
      total++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_word(i)) begin
        bad++; $display("FAIL full_write%0d: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], ADDR_W'(i), exp_word(i));
      end
    end
    for (int i = 1; i < wr_cyc.size(); i++) begin
      total++;
      if (wr_cyc[i] - wr_cyc[i-1] != 64) begin
        bad++; $display("FAIL full_spacing%0d: got %0d want 64", i, wr_cyc[i] - wr_cyc[i-1]);
      end
    end
    total++; if (wide_cnt != 0) begin bad++; $display("FAIL full_wren_width: wide pulses got %0d want 0", wide_cnt); end
    total++; if (flags_out !== 32'h43424140) begin bad++; $display("FAIL full_flags: got %h want 43424140", flags_out); end
    total++; if (ready_rise_cyc - csn_rise_cyc != SETTLE) begin
      bad++; $display("FAIL full_settle: got %0d want %0d", ready_rise_cyc - csn_rise_cyc, SETTLE);
    end
    total++; if (checksum_err !== 1'b0) begin bad++; $display("FAIL full_cksum: got %b want 0", checksum_err); end
    total++; if (loading !== 1'b0 || flash_csn !== 1'b1) begin
      bad++; $display("FAIL full_idle: loading=%b csn=%b want 0/1", loading, flash_csn);
    end
  endtask

  task automatic test_reload_mid_data();
    bit ok;
    clear_log();
    pulse_reload(4'd0);
    total++; if (cart_ready !== 1'b0 || flags_out !== 32'h0) begin
      bad++; $display("FAIL reload_clear: ready=%b flags=%h want 0/0", cart_ready, flags_out);
    end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (wr_addr.size() >= 5) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL reload_wait_w4: writes got %0d want 5", wr_addr.size()); end
    repeat (20) @(negedge clock);
    pulse_reload(4'd2);
    total++; if ({flash_csn, flash_sck, mem_wren, cart_ready, loading} !== 5'b10000 || flags_out !== 32'h0) begin
      bad++; $display("FAIL reload_abort: csn/sck/wren/ready/loading got %b flags=%h want 10000/0",
                      {flash_csn, flash_sck, mem_wren, cart_ready, loading}, flags_out);
    end
    total++; if (wr_addr.size() != 5) begin bad++; $display("FAIL reload_no_w5: writes got %0d want 5", wr_addr.size()); end
    clear_log();
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL reload_timeout: cart_ready got 0 want 1"); end
    total++; if (last_cmd !== 32'h03180000) begin bad++; $display("FAIL reload_cmd: got %h want 03180000", last_cmd); end
    total++; if (wr_addr.size() != IMAGE_WORDS) begin bad++; $display("FAIL reload_count: got %0d want %0d", wr_addr.size(), IMAGE_WORDS); end
    if (wr_addr.size() == IMAGE_WORDS) begin
      total++; if (wr_addr[0] !== '0 || wr_data[0] !== 32'h03020100) begin
        bad++; $display("FAIL reload_first: got %h/%h want 0/03020100", wr_addr[0], wr_data[0]);
      end
      total++; if (wr_addr[15] !== 4'hF || wr_data[15] !== 32'h3F3E3D3C) begin
        bad++; $display("FAIL reload_last: got %h/%h want f/3f3e3d3c", wr_addr[15], wr_data[15]);
      end
    end
    total++; if (flags_out !== 32'h43424140) begin bad++; $display("FAIL reload_flags: got %h want 43424140", flags_out); end
  endtask

  task automatic test_reload_hold();
    bit ok;
    int held_bad;
    clear_log();
    held_bad = 0;
    @(negedge clock);
    reload = 1'b1;
    index  = 4'd1;
    repeat (5) begin
      @(negedge clock);
      if (flash_csn !== 1'b1 || loading !== 1'b0) held_bad++;
    end
    reload = 1'b0;
    total++; if (held_bad != 0) begin bad++; $display("FAIL hold_gap: active cycles got %0d want 0", held_bad); end
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL hold_timeout: cart_ready got 0 want 1"); end
    total++; if (last_cmd !== 32'h03140000) begin bad++; $display("FAIL hold_cmd: got %h want 03140000", last_cmd); end
    total++; if (wr_addr.size() != IMAGE_WORDS || (wr_data.size() > 0 && wr_data[0] !== 32'h03020100)) begin
      bad++; $display("FAIL hold_data: count %0d want %0d, first %h want 03020100",
                      wr_addr.size(), IMAGE_WORDS, wr_data.size() > 0 ? wr_data[0] : 32'hx);
    end
  endtask

  task automatic test_truncation();
    int unsigned start;
    bit ok;
    start = hi_cmd_cnt;
    @(negedge clock);
    reload_hi = 1'b1;
    index_hi  = 4'd15;
    @(negedge clock);
    reload_hi = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (hi_cmd_cnt != start) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL trunc_timeout: command got none want one"); end
    total++; if (hi_cmd[31:24] !== 8'h03) begin bad++; $display("FAIL trunc_b0: got %h want 03", hi_cmd[31:24]); end
    total++; if (hi_cmd[23:16] !== 8'h2C) begin bad++; $display("FAIL trunc_b1: got %h want 2c", hi_cmd[23:16]); end
    total++; if (hi_cmd[15:8]  !== 8'h00) begin bad++; $display("FAIL trunc_b2: got %h want 00", hi_cmd[15:8]); end
    total++; if (hi_cmd[7:0]   !== 8'h00) begin bad++; $display("FAIL trunc_b3: got %h want 00", hi_cmd[7:0]); end
  endtask

  task automatic test_reset_mid_settle();
    bit ok;
    bit seen;
    pulse_reload(4'd3);
    ok   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (seen && loading === 1'b0) begin ok = 1'b1; break; end
      if (loading === 1'b1) seen = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL settle_wait: loading end got none want one"); end
    repeat (3) @(negedge clock);
    total++; if (cart_ready !== 1'b0 || flags_out !== 32'h43424140) begin
      bad++; $display("FAIL settle_state: ready=%b flags=%h want 0/43424140", cart_ready, flags_out);
    end
    #2 reset = 1'b1;
    #1;
    total++; if ({flash_csn, flash_sck, flash_mosi, mem_wren, loading, cart_ready, checksum_err} !== 7'b1000000) begin
      bad++; $display("FAIL rst_async_bits: got %b want 1000000",
                      {flash_csn, flash_sck, flash_mosi, mem_wren, loading, cart_ready, checksum_err});
    end
    total++; if ({mem_addr, mem_wdata, flags_out} !== '0) begin
      bad++; $display("FAIL rst_async_buses: addr=%h wdata=%h flags=%h want 0", mem_addr, mem_wdata, flags_out);
    end
    @(negedge clock);
    clear_log();
    reset = 1'b0;
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_reload_timeout: cart_ready got 0 want 1"); end
    total++; if (last_cmd !== 32'h03100000) begin bad++; $display("FAIL rst_reload_cmd: got %h want 03100000", last_cmd); end
    total++; if (wr_addr.size() != IMAGE_WORDS || (wr_addr.size() > 0 && (wr_addr[0] !== '0 || wr_data[0] !== 32'h03020100))) begin
      bad++; $display("FAIL rst_reload_data: count %0d want %0d, first %h/%h want 0/03020100", wr_addr.size(), IMAGE_WORDS,
                      wr_addr.size() > 0 ? wr_addr[0] : 4'hx, wr_data.size() > 0 ? wr_data[0] : 32'hx);
    end
    total++; if (flags_out !== 32'h43424140) begin bad++; $display("FAIL rst_reload_flags: got %h want 43424140", flags_out); end
  endtask

`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    clear_log();
    corrupt = 1'b1;
    pulse_reload(4'd0);
    wait_ready(ok);
    corrupt = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL cksum_timeout: cart_ready got 0 want 1"); end
    total++; if (checksum_err !== 1'b1 || cart_ready !== 1'b1) begin
      bad++; $display("FAIL cksum_err: err=%b ready=%b want 1/1", checksum_err, cart_ready);
    end
    total++; if (wr_data.size() < 2 || wr_data[1] !== 32'h0706FA04) begin
      bad++; $display("FAIL cksum_word1: got %h want 0706fa04", wr_data.size() > 1 ? wr_data[1] : 32'hx);
    end
  endtask
`endif

  initial begin
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < IMAGE_WORDS; i++) sum = sum + exp_word(i);
    exp_s = -(sum + 32'h43424140);

    test_reset();
    test_full_load();
    test_reload_mid_data();
    test_reload_hold();
    test_truncation();
    test_reset_mid_settle();
`ifdef CART_IMAGE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
